// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, baud-rate table and receiver FSM encoding.
// Divisors are derived from the system clock frequency at elaboration.
package uart_pkg;

  localparam int SAMPLES_PER_BIT = 16;
  localparam int PHASE_W         = $clog2(SAMPLES_PER_BIT);
  localparam int DIV_W           = 14;
  localparam int FRAME_BITS      = 8;
  localparam int BIT_CNT_W       = $clog2(FRAME_BITS);

  localparam int unsigned BAUD_RATE [8] = '{
    300, 1200, 4800, 9600, 19200, 38400, 57600, 115200
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Nearest-integer clk/(16*baud); never below 1 so slow clocks still tick.
  function automatic logic [DIV_W-1:0] baud_div(
    input int unsigned clk_freq,
    input logic [2:0]  sel
  );
    int unsigned baud;
    int unsigned d;
    baud = BAUD_RATE[sel];
    d = (clk_freq + 8 * baud) / (16 * baud);
    if (d == 0) d = 1;
    return d[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversampling tick generator with restartable phase.
// baud_sel is captured on restart so one frame keeps a single rate.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic [2:0]         baud_sel,
  output logic               tick,
  output logic [PHASE_W-1:0] phase
);

  logic [2:0]         sel_q, sel_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0]   div;

  assign div   = baud_div(CLK_FREQ, sel_q);
  assign phase = phase_q;

  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    tick    = 1'b0;
    if (restart) begin
      sel_d   = baud_sel;
      cnt_d   = '0;
      phase_d = '0;
    end else if (cnt_q >= div - 1'b1) begin
      tick    = 1'b1;
      cnt_d   = '0;
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: start/8 data/parity/stop receiver, 16x oversampled.
// Define UART_RX_MAJORITY_EN for a 3-sample majority vote per bit.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       rx_D,
  input  logic [2:0] baud_sel,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferror,
  output logic       rx_perror
);

  localparam logic [PHASE_W-1:0] MID = PHASE_W'(OVERSAMPLE / 2 - 1);
  localparam logic ODD = 1'(PARITY_ODD);

  rx_state_e state_q, state_d;

  logic [1:0]           sync_q;
  logic                 prev_q;
  logic [7:0]           sh_q, sh_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 par_bad_q, par_bad_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  logic                 rxs;
  logic                 fall;
  logic                 restart;
  logic                 tick;
  logic [PHASE_W-1:0]   phase;
  logic                 samp_stb;
  logic                 samp_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_D};
      prev_q <= sync_q[1];
    end
  end

  assign rxs  = sync_q[1];
  assign fall = prev_q & ~rxs;

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .clk      (clk),
    .rst_n    (reset),
    .restart  (restart),
    .baud_sel (baud_sel),
    .tick     (tick),
    .phase    (phase)
  );

`ifdef UART_RX_MAJORITY_EN
  logic m0_q, m0_d;
  logic m1_q, m1_d;

  always_comb begin
    m0_d = m0_q;
    m1_d = m1_q;
    if (tick && phase == MID - 1'b1) m0_d = rxs;
    if (tick && phase == MID)        m1_d = rxs;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_q <= 1'b1;
      m1_q <= 1'b1;
    end else begin
      m0_q <= m0_d;
      m1_q <= m1_d;
    end
  end

  // Vote on ticks 7/8/9, decided on tick 9.
  assign samp_stb = tick && (phase == MID + 1'b1);
  assign samp_bit = (m0_q & m1_q) | (m0_q & rxs) | (m1_q & rxs);
`else
  assign samp_stb = tick && (phase == MID);
  assign samp_bit = rxs;
`endif

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    restart   = 1'b0;
    if (!rx_en) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fall) begin
            restart = 1'b1;
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (samp_stb) begin
            if (samp_bit) begin
              state_d = ST_IDLE;
            end else begin
              ferr_d    = 1'b0;
              perr_d    = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (samp_stb) begin
            sh_d      = {samp_bit, sh_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1))
              state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (samp_stb) begin
            par_bad_d = ((^sh_q) ^ samp_bit) != ODD;
            state_d   = ST_STOP;
          end
        end
        ST_STOP: begin
          if (samp_stb) begin
            data_d = sh_q;
            if (samp_bit) begin
              if (par_bad_q) perr_d = 1'b1;
              else           valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d = 1'b1;
              if (par_bad_q) perr_d = 1'b1;
              state_d = ST_BREAK;
            end
          end
        end
        // A line held low must go high before a new start is armed.
        ST_BREAK: begin
          if (rxs) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_ferror = ferr_q;
  assign rx_perror = perr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and random frames against a frame-level model.
// A 1 MHz nominal clock keeps the slowest rate short enough to sweep.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CLK_FREQ = 1_000_000;
  localparam int PO       = 0;
  // round(1e6 / (16 * baud)) for 300 .. 115200
  localparam int DIV [8] = '{208, 52, 13, 7, 3, 2, 1, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx_D = 1'b1;
  logic [2:0] baud_sel = 3'd7;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferror;
  logic       rx_perror;

  int tests = 0;
  int fails = 0;
  int vcnt = 0;
  int verr = 0;

  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_perr = 1'b0;
  int         m_vcnt = 0;

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (16),
    .PARITY_ODD (PO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_en     (rx_en),
    .rx_D      (rx_D),
    .baud_sel  (baud_sel),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferror (rx_ferror),
    .rx_perror (rx_perror)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt = vcnt + 1;
      if (rx_ferror || rx_perror) verr = verr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s_data", tag), 32'(rx_data), 32'(m_data));
    chk($sformatf("%s_ferr", tag), 32'(rx_ferror), 32'(m_ferr));
    chk($sformatf("%s_perr", tag), 32'(rx_perror), 32'(m_perr));
    chk($sformatf("%s_vcnt", tag), 32'(vcnt), 32'(m_vcnt));
  endtask

  task automatic model_frame(input logic [7:0] d, input logic p,
                             input logic stop);
    logic good;
    good = (($countones(d) + int'(p)) % 2) == PO;
    m_data = d;
    m_ferr = !stop;
    m_perr = !good;
    if (stop && good) m_vcnt++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // act: 1 drop rx_en at D3, 2 reset at D5, 3 flip baud_sel at D4,
  // 4 one-cycle high glitch at tick 8 of D3
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic stop, input int act);
    logic [10:0] bits;
    int bc;
    bits = {stop, p, d, 1'b0};
    bc = 16 * DIV[baud_sel];
    for (int i = 0; i < 11; i++) begin
      rx_D = bits[i];
      if (i == 3) begin
        chk("start_clears_ferr", 32'(rx_ferror), 32'd0);
        chk("start_clears_perr", 32'(rx_perror), 32'd0);
      end
      if (act == 1 && i == 4) rx_en = 1'b0;
      if (act == 2 && i == 6) reset = 1'b0;
      if (act == 3 && i == 5) baud_sel = (baud_sel == 3'd0) ? 3'd7 : 3'd0;
      if (act == 4 && i == 4) begin
        cycles(8);
        rx_D = ~bits[i];
        cycles(1);
        rx_D = bits[i];
        cycles(bc - 9);
      end else begin
        cycles(bc);
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       bad_s;
    logic [2:0] sv;
    int         bc;

    cycles(3);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_ferr", 32'(rx_ferror), 32'd0);
    chk("rst_perr", 32'(rx_perror), 32'd0);
    reset = 1'b1;
    rx_en = 1'b1;
    cycles(20);

    baud_sel = 3'd7;
    send_frame(8'hAA, 1'b0, 1'b1, 0);
    model_frame(8'hAA, 1'b0, 1'b1);
    cycles(4);
    check_all("t1_aa");

    baud_sel = 3'd3;
    send_frame(8'h89, 1'b0, 1'b1, 0);
    model_frame(8'h89, 1'b0, 1'b1);
    cycles(4);
    check_all("t2_perr");

    // Short low pulse on idle line: false start, flags untouched.
    rx_D = 1'b0;
    cycles(5 * DIV[3]);
    rx_D = 1'b1;
    cycles(32 * DIV[3]);
    check_all("t4_false_start");

    baud_sel = 3'd7;
    bc = 16 * DIV[7];
    send_frame(8'h55, 1'b0, 1'b0, 0);
    model_frame(8'h55, 1'b0, 1'b0);
    cycles(3 * bc);
    check_all("t3_break");
    rx_D = 1'b1;
    cycles(2 * bc);
    send_frame(8'hCC, 1'b0, 1'b1, 0);
    model_frame(8'hCC, 1'b0, 1'b1);
    cycles(4);
    check_all("t3_after_break");

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h00, 1'b0, 1'b1, 4);
    model_frame(8'h00, 1'b0, 1'b1);
    cycles(4);
    check_all("t4_glitch_vote");
`endif

    send_frame(8'hAA, 1'b0, 1'b1, 1);
    m_ferr = 1'b0;
    m_perr = 1'b0;
    cycles(4);
    check_all("t5_rx_en_abort");
    rx_en = 1'b1;
    cycles(2 * bc);

    send_frame(8'hAA, 1'b0, 1'b1, 2);
    m_data = 8'h00;
    m_ferr = 1'b0;
    m_perr = 1'b0;
    check_all("t5_reset_mid");
    reset = 1'b1;
    cycles(2 * bc);
    check_all("t5_reset_released");
    send_frame(8'hAA, 1'b0, 1'b1, 0);
    model_frame(8'hAA, 1'b0, 1'b1);
    cycles(4);
    check_all("t5_after_reset");

    for (int s = 0; s < 8; s++) begin
      baud_sel = 3'(s);
      send_frame(8'hCC, 1'b0, 1'b1, (s == 3) ? 3 : 0);
      baud_sel = 3'(s);
      model_frame(8'hCC, 1'b0, 1'b1);
      cycles(4);
      check_all($sformatf("t6_sweep%0d", s));
    end

    for (int n = 0; n < 20; n++) begin
      sv = 3'(5 + $urandom_range(0, 2));
      baud_sel = sv;
      bc = 16 * DIV[sv];
      d = 8'($urandom);
      p = (^d) ^ 1'(PO) ^ ($urandom_range(0, 3) == 0);
      bad_s = ($urandom_range(0, 5) == 0);
      send_frame(d, p, !bad_s, 0);
      model_frame(d, p, !bad_s);
      if (bad_s) begin
        cycles(2 * bc);
        check_all($sformatf("rnd%0d_low", n));
        rx_D = 1'b1;
        cycles(2 * bc);
      end else begin
        cycles(4);
      end
      check_all($sformatf("rnd%0d", n));
    end

    chk("valid_with_flag", 32'(verr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
